// File: rtl/servant_spi_arbiter_if.sv
// Wishbone-style word bus between the CPU ports, the arbiter and the SPI memory master.
// The master drives the request fields; the slave returns rd_data and a one-cycle ack.
interface servant_spi_arbiter_if #(
  parameter int AW = 22
);
  logic [AW-1:0] address;
  logic [31:0]   wr_data;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic [31:0]   rd_data;
  logic          ack;

  modport master (output address, wr_data, sel, we, cyc, input  rd_data, ack);
  modport slave  (input  address, wr_data, sel, we, cyc, output rd_data, ack);
endinterface

// File: rtl/servant_spi_arbiter.sv
// Shares the SPI memory master between the instruction and data buses, with a per-transaction timeout.
// Define SPI_ARB_WREN_EN to precede every dbus write (sel != 0) with an automatic WREN command.
module servant_spi_arbiter #(
  parameter int ADDRESS_WIDTH = 24,
  parameter int GAP_CYCLES    = 2,
  parameter int TIMEOUT       = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  servant_spi_arbiter_if.slave  ibus,
  servant_spi_arbiter_if.slave  dbus,
  servant_spi_arbiter_if.master mem,
  output logic                  timeout_err
);
  localparam int AW = ADDRESS_WIDTH - 2;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // RESP/WREN-ack cycle already counts as one low cycle of the gap
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [15:0]   TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WREN, GAP, XFER, RESP} state_t;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    sel;
    logic          we;
  } req_t;

  state_t        state;
  logic          last_grant;  // 1 = dbus
  logic          grant;
  req_t          lat;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   to_cnt;

  logic          pick_d;
  req_t          pick_req;
  logic          want_wren;
  logic          to_hit;
  logic          fin;
  logic          fin_to;
  logic [31:0]   resp_data;

  // ibus is read-only; its write-side fields are intentionally ignored
  logic unused_ibus;
  assign unused_ibus = ^{ibus.wr_data, ibus.sel, ibus.we};

  always_comb begin
    pick_d = dbus.cyc & (~ibus.cyc | ~last_grant);
    if (pick_d) pick_req = '{addr: dbus.address, wdata: dbus.wr_data, sel: dbus.sel, we: dbus.we};
    else        pick_req = '{addr: ibus.address, wdata: 32'h0,        sel: 4'hF,      we: 1'b0};
  end

`ifdef SPI_ARB_WREN_EN
  assign want_wren = pick_d & dbus.we & (dbus.sel != 4'h0);
`else
  assign want_wren = 1'b0;
`endif

  assign to_hit    = (TIMEOUT != 0) && ((to_cnt + 16'd1) == TO_LIMIT);
  assign fin       = ((state == XFER) && (mem.ack || to_hit)) ||
                     ((state == WREN) && !mem.ack && to_hit);
  assign fin_to    = fin && !mem.ack;
  assign resp_data = fin_to ? 32'hFFFF_FFFF : mem.rd_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      lat          <= '0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      mem.cyc      <= 1'b0;
      mem.we       <= 1'b0;
      mem.sel      <= 4'h0;
      mem.address  <= '0;
      mem.wr_data  <= '0;
      ibus.ack     <= 1'b0;
      ibus.rd_data <= '0;
      dbus.ack     <= 1'b0;
      dbus.rd_data <= '0;
      timeout_err  <= 1'b0;
    end else begin
      ibus.ack <= 1'b0;
      dbus.ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          else if (ibus.cyc || dbus.cyc) begin
            grant       <= pick_d;
            lat         <= pick_req;
            to_cnt      <= '0;
            mem.cyc     <= 1'b1;
            mem.address <= pick_req.addr;
            mem.wr_data <= pick_req.wdata;
            if (want_wren) begin
              mem.we  <= 1'b1;
              mem.sel <= 4'h0;
              state   <= WREN;
            end else begin
              mem.we  <= pick_req.we;
              mem.sel <= pick_req.sel;
              state   <= XFER;
            end
          end
        end
        WREN: begin
          if (mem.ack) begin
            mem.cyc <= 1'b0;
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else if (!fin) to_cnt <= to_cnt + 16'd1;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          else begin
            mem.cyc     <= 1'b1;
            mem.address <= lat.addr;
            mem.wr_data <= lat.wdata;
            mem.sel     <= lat.sel;
            mem.we      <= lat.we;
            to_cnt      <= '0;
            state       <= XFER;
          end
        end
        XFER: if (!fin) to_cnt <= to_cnt + 16'd1;
        RESP: begin
          last_grant <= grant;
          gap_cnt    <= GAP_LOAD;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // completion or abort: ack lands the cycle after the final mem_ack / timeout
      if (fin) begin
        mem.cyc  <= 1'b0;
        state    <= RESP;
        ibus.ack <= ~grant;
        dbus.ack <= grant;
        if (grant) dbus.rd_data <= resp_data;
        else       ibus.rd_data <= resp_data;
        if (fin_to) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/servant_spi_arbiter.md
# servant_spi_arbiter

Two-port arbiter and command sequencer in front of the SPI memory master. It shares the master's single Wishbone slave port between the CPU instruction bus (read-only) and data bus (read/write). Optionally, it prefixes every data write with a write-enable transaction. It also guards each downstream transaction with a timeout, so a stuck SPI device cannot hang the CPU.

## Interface
- ADDRESS_WIDTH, 24: byte-address width of the memory; the word address is ADDRESS_WIDTH-2 bits.
- GAP_CYCLES, 2: minimum cycles mem_cyc stays low between downstream transactions (≥1).
- TIMEOUT, 4096: cycles allowed per downstream transaction before abort; 0 disables the timeout.

- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- ibus_address  in  ADDRESS_WIDTH-2  instruction word address.
- ibus_cyc  in  1  instruction request; held until ibus_ack.
- ibus_rd_data  out  32  instruction read data; valid while ibus_ack=1.
- ibus_ack  out  1  one-cycle completion pulse.
- dbus_address  in  ADDRESS_WIDTH-2  data word address.
- dbus_wr_data  in  32  write data.
- dbus_sel  in  4  byte lanes; 4'h0 means a raw status/WREN command.
- dbus_we  in  1  write strobe.
- dbus_cyc  in  1  data request; held until dbus_ack.
- dbus_rd_data  out  32  data read data; valid while dbus_ack=1.
- dbus_ack  out  1  one-cycle completion pulse.
- mem_address  out  ADDRESS_WIDTH-2  to the SPI master.
- mem_wr_data  out  32  to the SPI master.
- mem_sel  out  4  to the SPI master.
- mem_we  out  1  to the SPI master.
- mem_cyc  out  1  to the SPI master; registered.
- mem_rd_data  in  32  from the SPI master.
- mem_ack  in  1  from the SPI master.
- timeout_err  out  1  sticky; set on any abort, cleared only by reset.

## Operation
- States: IDLE, WREN, GAP, XFER, RESP.
- IDLE:
  - Arbitrate when mem_cyc is low and the gap counter has expired.
  - Exactly one request: grant it.
  - Both requests: round-robin against last_grant. The reset value of last_grant is dbus, so ibus wins the first tie.
  - Latch the granted port's address, data, sel and we into registers.
  - Next state is WREN if `SPI_ARB_WREN_EN` is defined and the grant is dbus with we=1 and sel≠0. Otherwise next state is XFER.
- Downstream fields:
  - ibus grant: mem_we=0, mem_sel=4'hF, mem_wr_data=0.
  - dbus grant: the latched fields pass through unchanged.
- WREN:
  - Drive mem_cyc=1, mem_we=1, mem_sel=4'h0, mem_address=latched address.
  - On mem_ack go to GAP, then XFER.
  - No upstream ack is produced for the WREN transaction.
- GAP: hold mem_cyc=0 for GAP_CYCLES cycles.
- XFER:
  - Drive mem_cyc=1 with the latched fields.
  - On mem_ack, capture mem_rd_data and go to RESP.
- RESP:
  - Assert the granted port's ack for one cycle with the captured data.
  - Update last_grant.
  - Load the gap counter and return to IDLE.
- The non-granted port's ack stays 0 and its rd_data holds its previous value.
- If a requester drops cyc mid-transaction, the downstream transaction still completes and the ack is still pulsed; requesters must ignore unsolicited acks.
- Timeout (TIMEOUT≠0):
  - A 16-bit counter runs while mem_cyc=1 in WREN or XFER.
  - When the counter reaches TIMEOUT, go to RESP with data 32'hFFFF_FFFF and set timeout_err. A WREN-phase abort skips XFER.

## Timing
- Reset values: mem_cyc=0, mem_we=0, mem_sel=0, mem_address=0, mem_wr_data=0, both acks=0, both rd_data=0, timeout_err=0, state=IDLE, last_grant=dbus, all counters=0.
- Request to mem_cyc: mem_cyc rises 1 cycle after the cycle in which IDLE samples a request with the gap expired.
- mem_cyc falls in the cycle after mem_ack is sampled high; it never stays high for 2 cycles after an ack.
- Upstream ack is high exactly 1 cycle, one cycle after the final mem_ack (or the timeout cycle).
- Minimum spacing between mem_cyc pulses is GAP_CYCLES low cycles. This applies after every transaction, including WREN and aborts.
- mem_ack while mem_cyc=0 is ignored.
- A reset asserted mid-transaction forces reset values on the next edge; no ack is produced for the in-flight request.

## Configuration
- `SPI_ARB_WREN_EN`
  - Defined: every dbus write with sel≠0 becomes two downstream transactions, WREN then write, with a single upstream ack.
  - Undefined: the WREN state is unreachable and every request maps to one downstream transaction. Software issues WREN itself with sel=4'h0, we=1.

## Test plan
- ibus read of word 0x10 alone; model acks after 40 cycles with 0x00000297 -> mem_sel=F, mem_we=0; ibus_ack 1 cycle later with ibus_rd_data=0x00000297.
- ibus and dbus reads both asserted in the cycle after reset release -> ibus served first, dbus second. Repeat the simultaneous pair -> order alternates; mem_cyc gaps ≥2 cycles.
- With `SPI_ARB_WREN_EN`: dbus write sel=4'h3, data=0xDEADBEEF -> downstream transaction 1 has we=1, sel=0; cyc low 2 cycles; transaction 2 has sel=3, data=0xDEADBEEF; exactly one dbus_ack.
- Without the macro, same stimulus -> one downstream transaction with sel=3; one dbus_ack.
- TIMEOUT=100, model never acks a dbus read -> mem_cyc drops after 100 cycles; dbus_ack with 0xFFFF_FFFF; timeout_err=1 until reset.
- Reset pulsed during XFER -> all outputs at reset values next cycle, no ack; a subsequent ibus read completes normally.
